// File: rtl/id_stage.sv
// id_stage: RV32I/E decode with register file, scoreboard and a
// registered valid/ready handshake towards execute.
module id_stage #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_valid,
    input  logic [31:0]     i_if_instr,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_if_ready,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [31:0]     o_ex_instr,
    output logic [XLEN-1:0] o_ex_rs1_data,
    output logic [XLEN-1:0] o_ex_rs2_data,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [4:0]      o_ex_rd,
    output logic            o_ex_reg_wen,
    output logic            o_ex_mem_rd,
    output logic            o_ex_mem_wr,
    output logic            o_ex_illegal,
    output logic            o_ex_halt,
    input  logic            i_wb_wen,
    input  logic [4:0]      i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_flush
);

    function automatic logic in_rf(input logic [4:0] idx);
        return {1'b0, idx} < 6'(NREGS);
    endfunction

    logic [XLEN-1:0]  r_rf [1:NREGS-1];
    logic [NREGS-1:1] r_busy;
    logic             r_halted;

    logic             r_ex_valid;
    logic [XLEN-1:0]  r_ex_pc;
    logic [31:0]      r_ex_instr;
    logic [XLEN-1:0]  r_ex_rs1_data;
    logic [XLEN-1:0]  r_ex_rs2_data;
    logic [XLEN-1:0]  r_ex_imm;
    logic [4:0]       r_ex_rd;
    logic             r_ex_reg_wen;
    logic             r_ex_mem_rd;
    logic             r_ex_mem_wr;
    logic             r_ex_illegal;
    logic             r_ex_halt;

    logic [31:0]      w_i;
    logic [6:0]       w_op;
    logic [4:0]       w_rd;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic             w_lui, w_auipc, w_jal, w_jalr;
    logic             w_br, w_ld, w_st, w_opi;
    logic             w_opr, w_fence, w_sys;
    logic             w_use1, w_use2, w_wr, w_known;
    logic             w_legal;
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    logic [XLEN-1:0]  w_rs1_data;
    logic [XLEN-1:0]  w_rs2_data;
    logic             w_busy1, w_busy2;
    logic             w_hit1, w_hit2;
    logic             w_stall;
    logic             w_accept;
    logic             w_issue;

    assign w_i   = i_if_instr;
    assign w_op  = w_i[6:0];
    assign w_rd  = w_i[11:7];
    assign w_rs1 = w_i[19:15];
    assign w_rs2 = w_i[24:20];

    assign w_lui   = (w_op == 7'b0110111);
    assign w_auipc = (w_op == 7'b0010111);
    assign w_jal   = (w_op == 7'b1101111);
    assign w_jalr  = (w_op == 7'b1100111);
    assign w_br    = (w_op == 7'b1100011);
    assign w_ld    = (w_op == 7'b0000011);
    assign w_st    = (w_op == 7'b0100011);
    assign w_opi   = (w_op == 7'b0010011);
    assign w_opr   = (w_op == 7'b0110011);
    assign w_fence = (w_op == 7'b0001111);
    assign w_sys   = (w_op == 7'b1110011);

    always_comb begin
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        w_wr    = 1'b0;
        w_known = 1'b1;
        w_imm32 = '0;
        unique case (1'b1)
            w_lui, w_auipc: begin
                w_wr    = 1'b1;
                w_imm32 = {w_i[31:12], 12'b0};
            end
            w_jal: begin
                w_wr    = 1'b1;
                w_imm32 = {{12{w_i[31]}}, w_i[19:12],
                           w_i[20], w_i[30:21], 1'b0};
            end
            w_jalr, w_ld, w_opi: begin
                w_wr    = 1'b1;
                w_use1  = 1'b1;
                w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
            end
            w_br: begin
                w_use1  = 1'b1;
                w_use2  = 1'b1;
                w_imm32 = {{20{w_i[31]}}, w_i[7],
                           w_i[30:25], w_i[11:8], 1'b0};
            end
            w_st: begin
                w_use1  = 1'b1;
                w_use2  = 1'b1;
                w_imm32 = {{20{w_i[31]}},
                           w_i[31:25], w_i[11:7]};
            end
            w_opr: begin
                w_wr   = 1'b1;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            w_fence: begin
                w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
            end
            w_sys: begin
                w_imm32 = '0;
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
    end

    assign w_imm   = XLEN'($signed(w_imm32));
    assign w_legal = w_known
                   & ~(w_use1 & ~in_rf(w_rs1))
                   & ~(w_use2 & ~in_rf(w_rs2))
                   & ~(w_wr & ~in_rf(w_rd));

    // A writeback landing this cycle both forwards its data and
    // releases the busy bit it is about to clear.
    assign w_hit1 = WB_BYPASS & i_wb_wen & (i_wb_addr == w_rs1)
                  & (w_rs1 != 5'd0) & in_rf(w_rs1);
    assign w_hit2 = WB_BYPASS & i_wb_wen & (i_wb_addr == w_rs2)
                  & (w_rs2 != 5'd0) & in_rf(w_rs2);

    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        w_busy1    = 1'b0;
        w_busy2    = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (w_rs1 == 5'(i)) begin
                w_rs1_data = r_rf[i];
                w_busy1    = r_busy[i];
            end
            if (w_rs2 == 5'(i)) begin
                w_rs2_data = r_rf[i];
                w_busy2    = r_busy[i];
            end
        end
        if (w_hit1) w_rs1_data = i_wb_data;
        if (w_hit2) w_rs2_data = i_wb_data;
    end

    assign w_stall = (w_use1 & w_busy1 & ~w_hit1)
                   | (w_use2 & w_busy2 & ~w_hit2);

    assign o_if_ready = (~r_ex_valid | i_ex_ready) & ~w_stall
                      & ~i_flush & ~r_halted;
    assign w_accept = i_if_valid & o_if_ready;
    assign w_issue  = r_ex_valid & i_ex_ready & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 1; i < NREGS; i++) r_rf[i] <= '0;
            r_busy   <= '0;
            r_halted <= 1'b0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (i_wb_wen && i_wb_addr == 5'(i))
                    r_rf[i] <= i_wb_data;
                // set wins over a same-cycle clear
                if (w_issue && r_ex_reg_wen && r_ex_rd == 5'(i))
                    r_busy[i] <= 1'b1;
                else if (i_wb_wen && i_wb_addr == 5'(i))
                    r_busy[i] <= 1'b0;
            end
            if (w_accept && w_sys) r_halted <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_instr    <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rd       <= '0;
            r_ex_reg_wen  <= 1'b0;
            r_ex_mem_rd   <= 1'b0;
            r_ex_mem_wr   <= 1'b0;
            r_ex_illegal  <= 1'b0;
            r_ex_halt     <= 1'b0;
        end else if (i_flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid    <= 1'b1;
            r_ex_pc       <= i_if_pc;
            r_ex_instr    <= w_i;
            r_ex_rs1_data <= w_rs1_data;
            r_ex_rs2_data <= w_rs2_data;
            r_ex_imm      <= w_imm;
            r_ex_rd       <= w_rd;
            r_ex_reg_wen  <= w_wr & w_legal & (w_rd != 5'd0);
            r_ex_mem_rd   <= w_ld & w_legal;
            r_ex_mem_wr   <= w_st & w_legal;
            r_ex_illegal  <= ~w_legal;
            r_ex_halt     <= w_sys;
        end else if (w_issue) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign o_ex_valid    = r_ex_valid;
    assign o_ex_pc       = r_ex_pc;
    assign o_ex_instr    = r_ex_instr;
    assign o_ex_rs1_data = r_ex_rs1_data;
    assign o_ex_rs2_data = r_ex_rs2_data;
    assign o_ex_imm      = r_ex_imm;
    assign o_ex_rd       = r_ex_rd;
    assign o_ex_reg_wen  = r_ex_reg_wen;
    assign o_ex_mem_rd   = r_ex_mem_rd;
    assign o_ex_mem_wr   = r_ex_mem_wr;
    assign o_ex_illegal  = r_ex_illegal;
    assign o_ex_halt     = r_ex_halt;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: two id_stage instances (RV32I+bypass, RV32E no bypass)
// driven by directed and random traffic against a behavioural model.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        if_valid [2];
    logic [31:0] if_instr [2];
    logic [31:0] if_pc    [2];
    logic        if_ready [2];
    logic        ex_valid [2];
    logic        ex_ready [2];
    logic [31:0] ex_pc    [2];
    logic [31:0] ex_instr [2];
    logic [31:0] ex_rs1   [2];
    logic [31:0] ex_rs2   [2];
    logic [31:0] ex_imm   [2];
    logic [4:0]  ex_rd    [2];
    logic        ex_wen   [2];
    logic        ex_mrd   [2];
    logic        ex_mwr   [2];
    logic        ex_ill   [2];
    logic        ex_halt  [2];
    logic        wb_wen   [2];
    logic [4:0]  wb_addr  [2];
    logic [31:0] wb_data  [2];
    logic        flush    [2];

    id_stage #(.XLEN(32), .NREGS(32), .WB_BYPASS(1'b1)) u0 (
        .i_clk(clk), .i_rst(rst),
        .i_if_valid(if_valid[0]), .i_if_instr(if_instr[0]),
        .i_if_pc(if_pc[0]), .o_if_ready(if_ready[0]),
        .o_ex_valid(ex_valid[0]), .i_ex_ready(ex_ready[0]),
        .o_ex_pc(ex_pc[0]), .o_ex_instr(ex_instr[0]),
        .o_ex_rs1_data(ex_rs1[0]), .o_ex_rs2_data(ex_rs2[0]),
        .o_ex_imm(ex_imm[0]), .o_ex_rd(ex_rd[0]),
        .o_ex_reg_wen(ex_wen[0]), .o_ex_mem_rd(ex_mrd[0]),
        .o_ex_mem_wr(ex_mwr[0]), .o_ex_illegal(ex_ill[0]),
        .o_ex_halt(ex_halt[0]), .i_wb_wen(wb_wen[0]),
        .i_wb_addr(wb_addr[0]), .i_wb_data(wb_data[0]),
        .i_flush(flush[0])
    );

    id_stage #(.XLEN(32), .NREGS(16), .WB_BYPASS(1'b0)) u1 (
        .i_clk(clk), .i_rst(rst),
        .i_if_valid(if_valid[1]), .i_if_instr(if_instr[1]),
        .i_if_pc(if_pc[1]), .o_if_ready(if_ready[1]),
        .o_ex_valid(ex_valid[1]), .i_ex_ready(ex_ready[1]),
        .o_ex_pc(ex_pc[1]), .o_ex_instr(ex_instr[1]),
        .o_ex_rs1_data(ex_rs1[1]), .o_ex_rs2_data(ex_rs2[1]),
        .o_ex_imm(ex_imm[1]), .o_ex_rd(ex_rd[1]),
        .o_ex_reg_wen(ex_wen[1]), .o_ex_mem_rd(ex_mrd[1]),
        .o_ex_mem_wr(ex_mwr[1]), .o_ex_illegal(ex_ill[1]),
        .o_ex_halt(ex_halt[1]), .i_wb_wen(wb_wen[1]),
        .i_wb_addr(wb_addr[1]), .i_wb_data(wb_data[1]),
        .i_flush(flush[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc, ins, r1, r2, imm;
        logic [4:0]  rd;
        logic        wen, mrd, mwr, ill, hlt, u1, u2;
    } exo_t;

    localparam logic [6:0] OPS [10] = '{
        7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
        7'h03, 7'h23, 7'h13, 7'h33, 7'h0f
    };

    int          n_cmp = 0;
    int          n_bad = 0;
    exo_t        mo     [2];
    logic [31:0] m_rf   [2][32];
    bit          m_busy [2][32];
    bit          m_halt [2];
    int          pq0 [$];
    int          pq1 [$];

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic int nregs(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic bit byp(input int k);
        return (k == 0);
    endfunction

    function automatic exo_t dec(input logic [31:0] x, input int n);
        exo_t o;
        bit   wr, legal;
        int   rd, r1, r2;
        rd = int'(x[11:7]);
        r1 = int'(x[19:15]);
        r2 = int'(x[24:20]);
        o.v = 0; o.pc = 0; o.ins = 0; o.r1 = 0; o.r2 = 0;
        o.imm = 0; o.rd = x[11:7];
        o.mrd = 0; o.mwr = 0; o.hlt = 0; o.u1 = 0; o.u2 = 0;
        wr = 0;
        legal = 1;
        case (x[6:0])
            7'h37, 7'h17: begin
                wr = 1; o.imm = {x[31:12], 12'h000};
            end
            7'h6f: begin
                wr = 1;
                o.imm = {{12{x[31]}}, x[19:12], x[20], x[30:21], 1'b0};
            end
            7'h67, 7'h13: begin
                wr = 1; o.u1 = 1; o.imm = {{20{x[31]}}, x[31:20]};
            end
            7'h03: begin
                wr = 1; o.u1 = 1; o.mrd = 1;
                o.imm = {{20{x[31]}}, x[31:20]};
            end
            7'h63: begin
                o.u1 = 1; o.u2 = 1;
                o.imm = {{20{x[31]}}, x[7], x[30:25], x[11:8], 1'b0};
            end
            7'h23: begin
                o.u1 = 1; o.u2 = 1; o.mwr = 1;
                o.imm = {{20{x[31]}}, x[31:25], x[11:7]};
            end
            7'h33: begin
                wr = 1; o.u1 = 1; o.u2 = 1;
            end
            7'h0f: o.imm = {{20{x[31]}}, x[31:20]};
            7'h73: o.hlt = 1;
            default: legal = 0;
        endcase
        if (o.u1 && r1 >= n) legal = 0;
        if (o.u2 && r2 >= n) legal = 0;
        if (wr && rd >= n) legal = 0;
        o.ill = !legal;
        o.wen = wr && legal && rd != 0;
        o.mrd = o.mrd && legal;
        o.mwr = o.mwr && legal;
        return o;
    endfunction

    function automatic bit busyq(input int k, input int idx);
        if (idx == 0 || idx >= nregs(k)) return 0;
        if (!m_busy[k][idx]) return 0;
        return !(byp(k) && wb_wen[k] && int'(wb_addr[k]) == idx);
    endfunction

    function automatic logic [31:0] rdv(input int k, input int idx);
        if (idx == 0 || idx >= nregs(k)) return 0;
        if (byp(k) && wb_wen[k] && int'(wb_addr[k]) == idx)
            return wb_data[k];
        return m_rf[k][idx];
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                m_rf[k][i] = 0;
                m_busy[k][i] = 0;
            end
            m_halt[k] = 0;
            mo[k] = dec(32'h0, 32);
            mo[k].imm = 0; mo[k].rd = 0; mo[k].ill = 0;
        end
        pq0.delete();
        pq1.delete();
    endtask

    task automatic model_cycle(input int k);
        exo_t  d, nx;
        bit    stall, rdy, acc, iss;
        int    r1, r2;
        string p;
        p  = $sformatf("u%0d.", k);
        r1 = int'(if_instr[k][19:15]);
        r2 = int'(if_instr[k][24:20]);
        d  = dec(if_instr[k], nregs(k));
        stall = (d.u1 && busyq(k, r1)) || (d.u2 && busyq(k, r2));
        rdy = (!mo[k].v || ex_ready[k]) && !stall
              && !flush[k] && !m_halt[k];
        check({p, "ready"}, if_ready[k], rdy);
        check({p, "valid"}, ex_valid[k], mo[k].v);
        check({p, "pc"}, ex_pc[k], mo[k].pc);
        check({p, "instr"}, ex_instr[k], mo[k].ins);
        check({p, "rs1"}, ex_rs1[k], mo[k].r1);
        check({p, "rs2"}, ex_rs2[k], mo[k].r2);
        check({p, "imm"}, ex_imm[k], mo[k].imm);
        check({p, "rd"}, ex_rd[k], mo[k].rd);
        check({p, "flags"},
              {ex_wen[k], ex_mrd[k], ex_mwr[k], ex_ill[k], ex_halt[k]},
              {mo[k].wen, mo[k].mrd, mo[k].mwr, mo[k].ill, mo[k].hlt});
        acc = if_valid[k] && rdy;
        iss = mo[k].v && ex_ready[k] && !flush[k];
        nx = mo[k];
        if (flush[k]) begin
            nx.v = 0;
        end else if (acc) begin
            nx = d;
            nx.v = 1;
            nx.pc = if_pc[k];
            nx.ins = if_instr[k];
            nx.r1 = rdv(k, r1);
            nx.r2 = rdv(k, r2);
            if (d.hlt) m_halt[k] = 1;
        end else if (iss) begin
            nx.v = 0;
        end
        if (wb_wen[k] && wb_addr[k] != 0
            && int'(wb_addr[k]) < nregs(k)) begin
            m_rf[k][wb_addr[k]] = wb_data[k];
            m_busy[k][wb_addr[k]] = 0;
        end
        if (iss && mo[k].wen) begin
            m_busy[k][mo[k].rd] = 1;
            if (k == 0) pq0.push_back(int'(mo[k].rd));
            else pq1.push_back(int'(mo[k].rd));
        end
        mo[k] = nx;
    endtask

    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) model_cycle(k);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        if_valid[k] = 0; if_instr[k] = 0; if_pc[k] = 0;
        ex_ready[k] = 0; flush[k] = 0;
        wb_wen[k] = 0; wb_addr[k] = 0; wb_data[k] = 0;
    endtask

    task automatic do_reset();
        for (int k = 0; k < 2; k++) idle(k);
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        mreset();
        #1;
        for (int k = 0; k < 2; k++)
            check($sformatf("u%0d.rst_ready", k), if_ready[k], 1);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] x;
        x = $urandom;
        if ($urandom_range(0, 9) == 0) begin
            x[6:0] = 7'($urandom);
            if (x[6:0] == 7'h73) x[6:0] = 7'h7f;
        end else begin
            x[6:0] = OPS[$urandom_range(0, 9)];
        end
        if ($urandom_range(0, 3) != 0) begin
            x[11:7]  = 5'($urandom_range(0, 7));
            x[19:15] = 5'($urandom_range(0, 7));
            x[24:20] = 5'($urandom_range(0, 7));
        end
        return x;
    endfunction

    initial begin
        rst = 1;
        for (int k = 0; k < 2; k++) idle(k);
        do_reset();

        for (int k = 0; k < 2; k++) begin
            if_valid[k] = 1; if_instr[k] = 32'h00500093;
            if_pc[k] = 0; ex_ready[k] = 1;
        end
        step();
        for (int k = 0; k < 2; k++) begin
            if_valid[k] = 0;
            check($sformatf("u%0d.addi_v", k), ex_valid[k], 1);
            check($sformatf("u%0d.addi_rd", k), ex_rd[k], 1);
            check($sformatf("u%0d.addi_imm", k), ex_imm[k], 5);
            check($sformatf("u%0d.addi_wen", k), ex_wen[k], 1);
        end
        step();

        for (int k = 0; k < 2; k++) begin
            if_valid[k] = 1; if_instr[k] = 32'h00108133;
            if_pc[k] = 4;
        end
        repeat (2) begin
            #1;
            for (int k = 0; k < 2; k++)
                check($sformatf("u%0d.add_stall", k), if_ready[k], 0);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            wb_wen[k] = 1; wb_addr[k] = 1; wb_data[k] = 5;
            ex_ready[k] = 0;
        end
        #1;
        for (int k = 0; k < 2; k++)
            check($sformatf("u%0d.wb_ready", k), if_ready[k], k == 0);
        step();
        for (int k = 0; k < 2; k++) wb_wen[k] = 0;
        #1;
        check("u1.late_ready", if_ready[1], 1);
        check("u0.add_v", ex_valid[0], 1);
        check("u0.add_rs1", ex_rs1[0], 5);
        check("u0.add_rs2", ex_rs2[0], 5);
        step();

        for (int k = 0; k < 2; k++) if_instr[k] = 32'h00500093;
        repeat (3) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d.hold_rdy", k), if_ready[k], 0);
                check($sformatf("u%0d.hold_v", k), ex_valid[k], 1);
                check($sformatf("u%0d.hold_ins", k), ex_instr[k],
                      32'h00108133);
                check($sformatf("u%0d.hold_rs1", k), ex_rs1[k], 5);
                check($sformatf("u%0d.hold_rs2", k), ex_rs2[k], 5);
                check($sformatf("u%0d.hold_rd", k), ex_rd[k], 2);
            end
            step();
        end

        for (int k = 0; k < 2; k++) flush[k] = 1;
        step();
        for (int k = 0; k < 2; k++) begin
            flush[k] = 0;
            check($sformatf("u%0d.flush_v", k), ex_valid[k], 0);
            if_instr[k] = 32'h001101B3;
            ex_ready[k] = 1;
        end
        #1;
        for (int k = 0; k < 2; k++)
            check($sformatf("u%0d.noflush_busy", k), if_ready[k], 1);
        step();

        for (int k = 0; k < 2; k++) if_instr[k] = 32'h00100A13;
        step();
        check("u0.x20_ill", ex_ill[0], 0);
        check("u0.x20_wen", ex_wen[0], 1);
        check("u1.x20_ill", ex_ill[1], 1);
        check("u1.x20_wen", ex_wen[1], 0);

        for (int k = 0; k < 2; k++) if_instr[k] = 32'h00100073;
        step();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d.halt", k), ex_halt[k], 1);
            if_instr[k] = 32'h00500093;
        end
        repeat (10) begin
            #1;
            for (int k = 0; k < 2; k++)
                check($sformatf("u%0d.halt_rdy", k), if_ready[k], 0);
            step();
        end
        do_reset();

        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            for (int k = 0; k < 2; k++) begin
                if_valid[k] = ($urandom_range(0, 3) != 0);
                if_instr[k] = rnd_instr();
                if_pc[k] = $urandom & 32'hffff_fffc;
                ex_ready[k] = ($urandom_range(0, 3) != 0);
                flush[k] = ($urandom_range(0, 29) == 0);
                wb_wen[k] = 0; wb_addr[k] = 0; wb_data[k] = 0;
            end
            if (pq0.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_wen[0] = 1;
                wb_addr[0] = 5'(pq0.pop_front());
                wb_data[0] = $urandom;
            end
            if (pq1.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_wen[1] = 1;
                wb_addr[1] = 5'(pq1.pop_front());
                wb_data[1] = $urandom;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
